// File: rtl/npu_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// npu_run_ctrl_if
// Bundles every non-clock signal of npu_run_ctrl: host run control, the input
// quad stream, the npu_top control/data pins, the drained-byte output stream,
// status flags and the FSM debug state.
//   master : the run controller (npu_run_ctrl)
//   slave  : host/test logic plus npu_top
//
// Handshakes: a beat moves on a rising clock edge where VALID and READY are both
// 1. The producer keeps DATA stable and VALID high until that edge; READY may
// depend combinationally on the consumer's inputs but never on VALID.
// -----------------------------------------------------------------------------
interface npu_run_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic             ABORT;
  logic [15:0]      SSFR_CFG;
  logic [CNT_W-1:0] NUM_VEC;
  logic [CNT_W-1:0] NUM_OUT;
  logic [31:0]      IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic             EN_CONFIG;
  logic             EN_FSM;
  logic [7:0]       DA;
  logic [7:0]       DB;
  logic [7:0]       DC;
  logic [7:0]       DD;
  logic             RD_EN;
  logic [7:0]       NPU_DOUT;
  logic             NPU_FULL;
  logic             NPU_EMPTY;
  logic [7:0]       OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [3:0]       STATE_DBG;

  modport master (
    input  START, ABORT, SSFR_CFG, NUM_VEC, NUM_OUT, IN_DATA, IN_VALID,
           NPU_DOUT, NPU_FULL, NPU_EMPTY, OUT_READY,
    output IN_READY, EN_CONFIG, EN_FSM, DA, DB, DC, DD, RD_EN,
           OUT_DATA, OUT_VALID, BUSY, DONE, ERR, STATE_DBG
  );

  modport slave (
    output START, ABORT, SSFR_CFG, NUM_VEC, NUM_OUT, IN_DATA, IN_VALID,
           NPU_DOUT, NPU_FULL, NPU_EMPTY, OUT_READY,
    input  IN_READY, EN_CONFIG, EN_FSM, DA, DB, DC, DD, RD_EN,
           OUT_DATA, OUT_VALID, BUSY, DONE, ERR, STATE_DBG
  );
endinterface

// File: rtl/npu_run_ctrl.sv
// -----------------------------------------------------------------------------
// npu_run_ctrl
// Host-side run sequencer for npu_top. On START it writes the SSFR (DA/DB with
// EN_CONFIG), pulses EN_FSM, streams NUM_VEC quads onto DA..DD, waits LAT_CYC
// cycles for the pipeline and then drains NUM_OUT bytes from npu_top's output
// FIFO to the OUT_* stream.
// Ports:
//   CLKEXT  - clock
//   RST_GLO - synchronous active-high reset (also clears ERR)
//   bus     - npu_run_ctrl_if.master: run control, input quad stream,
//             npu_top pins, output byte stream, BUSY/DONE/ERR, STATE_DBG
// -----------------------------------------------------------------------------
module npu_run_ctrl #(
  parameter int CNT_W   = 8,
  parameter int LAT_CYC = 16,
  parameter int TIMEOUT = 1000
) (
  input logic            CLKEXT,
  input logic            RST_GLO,
  npu_run_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CFG_GAP, S_ENA, S_STREAM, S_WAIT, S_DRAIN, S_FIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] nv_q, no_q, vec_cnt, out_cnt;
  logic [15:0]      tmr;           // WAIT length, then consecutive-empty count in DRAIN
  logic             en_config_q, en_fsm_q, rd_en_q, out_valid_q;
  logic             busy_q, done_q, err_q;
  logic [7:0]       da_q, db_q, dc_q, dd_q, out_data_q;

  logic             xfer, out_acc;
  logic [CNT_W-1:0] vec_nxt, out_nxt;

  assign xfer    = (state == S_STREAM) && bus.IN_VALID && !bus.NPU_FULL;
  assign out_acc = out_valid_q && bus.OUT_READY;
  assign vec_nxt = vec_cnt + CNT_W'(1);
  assign out_nxt = out_cnt + CNT_W'(1);

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO || bus.ABORT) begin
      // ABORT is a soft reset: everything but the sticky ERR returns to reset.
      state       <= S_IDLE;
      nv_q        <= '0;
      no_q        <= '0;
      vec_cnt     <= '0;
      out_cnt     <= '0;
      tmr         <= '0;
      en_config_q <= 1'b0;
      en_fsm_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      da_q        <= '0;
      db_q        <= '0;
      dc_q        <= '0;
      dd_q        <= '0;
      out_data_q  <= '0;
      if (RST_GLO) err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            nv_q        <= bus.NUM_VEC;
            no_q        <= bus.NUM_OUT;
            vec_cnt     <= '0;
            out_cnt     <= '0;
            err_q       <= 1'b0;
            da_q        <= bus.SSFR_CFG[15:8];
            db_q        <= bus.SSFR_CFG[7:0];
            en_config_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= S_CFG;
          end
        end
        S_CFG: begin
          en_config_q <= 1'b0;
          state       <= S_CFG_GAP;
        end
        S_CFG_GAP: begin
          en_fsm_q <= 1'b1;
          da_q     <= '0;
          db_q     <= '0;
          dc_q     <= '0;
          dd_q     <= '0;
          state    <= S_ENA;
        end
        S_ENA: begin
          en_fsm_q <= 1'b0;
          tmr      <= '0;
          state    <= (nv_q == '0) ? S_WAIT : S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            {da_q, db_q, dc_q, dd_q} <= bus.IN_DATA;
            vec_cnt <= vec_nxt;
            if (vec_nxt == nv_q) begin
              tmr   <= '0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (tmr == 16'(LAT_CYC - 1)) begin
            tmr <= '0;
            if (no_q == '0) begin
              done_q <= 1'b1;
              state  <= S_FIN;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        S_DRAIN: begin
          // RD_EN doubles as the read-pending flag: the byte is captured on the
          // edge that ends the RD_EN cycle, so at most one read is in flight.
          if (rd_en_q) begin
            rd_en_q     <= 1'b0;
            out_data_q  <= bus.NPU_DOUT;
            out_valid_q <= 1'b1;
          end else if (!out_valid_q && !bus.NPU_EMPTY) begin
            rd_en_q <= 1'b1;
          end
          if (out_acc) begin
            out_valid_q <= 1'b0;
            out_cnt     <= out_nxt;
          end
          if (out_acc && (out_nxt == no_q)) begin
            done_q <= 1'b1;
            state  <= S_FIN;
          end else if (bus.NPU_EMPTY) begin
            if (tmr == 16'(TIMEOUT - 1)) begin
              err_q       <= 1'b1;
              busy_q      <= 1'b0;
              rd_en_q     <= 1'b0;
              out_valid_q <= 1'b0;
              state       <= S_IDLE;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end else begin
            tmr <= '0;
          end
        end
        S_FIN: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = (state == S_STREAM) && !bus.NPU_FULL;
  assign bus.EN_CONFIG = en_config_q;
  assign bus.EN_FSM    = en_fsm_q;
  assign bus.DA        = da_q;
  assign bus.DB        = db_q;
  assign bus.DC        = dc_q;
  assign bus.DD        = dd_q;
  assign bus.RD_EN     = rd_en_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.STATE_DBG = state;

endmodule

// File: tb/tb_npu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_npu_run_ctrl
// Directed run sequence with random quads, FIFO bytes, FULL and sink stalls.
// npu_top is modelled as a byte queue (head on NPU_DOUT, pop on RD_EN); the
// expected run is described in cycle terms: CFG=1, GAP=2, ENA=3, stream window
// from cycle 4, WAIT of LAT cycles after the last transfer, first RD_EN one
// cycle into DRAIN, and TIMEOUT empty cycles before ERR.
// -----------------------------------------------------------------------------
module tb_npu_run_ctrl;
  localparam int CNT_W = 8;
  localparam int LAT   = 16;
  localparam int TMO   = 1000;

  // ---------------- clock / reset ----------------
  logic CLKEXT = 1'b0;
  logic RST_GLO = 1'b1;
  always #5 CLKEXT = ~CLKEXT;

  npu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  npu_run_ctrl #(.CNT_W(CNT_W), .LAT_CYC(LAT), .TIMEOUT(TMO)) dut (
    .CLKEXT (CLKEXT),
    .RST_GLO(RST_GLO),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- scoreboard / models ----------------
  logic [7:0]  exp_q[$];   // bytes the OUT port must deliver, in order
  logic [7:0]  fifo_q[$];  // npu_top output FIFO contents
  logic [31:0] quad_q[$];  // quads offered on IN_DATA
  bit          empty_stuck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifo_pins();
    bus.NPU_DOUT  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    bus.NPU_EMPTY = empty_stuck || (fifo_q.size() == 0);
  endtask

  task automatic idle_inputs();
    bus.START     = 1'b0;
    bus.ABORT     = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = 32'h0;
    bus.NPU_FULL  = 1'b0;
    bus.OUT_READY = 1'b0;
    drive_fifo_pins();
  endtask

  // ---------------- driver + checker for one run ----------------
  // full_mode: 0 never full, 1 FULL for cycles 7..9, 2 random FULL
  // sink_mode: 0 OUT_READY held, 1 OUT_READY random
  task automatic run(input logic [15:0] cfg, input int nv, input int nout,
                     input int full_mode, input int sink_mode, input bit stuck,
                     input int abort_cyc);
    int c = 0, sent = 0, t_last = -10, ws, first_rd = -1;
    int rd_cnt = 0, acc = 0, done_cnt = 0, busy_cyc = 0;
    bit pop_pend = 1'b0, ended = 1'b0;
    logic [31:0] last_quad = 32'h0;
    logic [7:0]  b;
    quad_q.delete(); fifo_q.delete(); exp_q.delete();
    for (int i = 0; i < nv; i++) quad_q.push_back($urandom());
    for (int i = 0; i < nout; i++) begin
      b = 8'($urandom());
      fifo_q.push_back(b);
      exp_q.push_back(b);
    end
    ws = (nv == 0) ? 4 : -1;
    @(posedge CLKEXT); #1;
    empty_stuck  = stuck;
    drive_fifo_pins();
    bus.SSFR_CFG = cfg;
    bus.NUM_VEC  = CNT_W'(nv);
    bus.NUM_OUT  = CNT_W'(nout);
    bus.START    = 1'b1;
    while (!ended && c < 3000) begin
      @(posedge CLKEXT); #1;
      c++;
      bus.START = (c == 5);  // a START while busy must be ignored
      bus.ABORT = (c == abort_cyc);
      if (pop_pend) begin
        void'(fifo_q.pop_front());
        pop_pend = 1'b0;
      end
      drive_fifo_pins();
      bus.IN_VALID = (sent < nv);
      bus.IN_DATA  = (sent < nv) ? quad_q[sent] : 32'h0;
      case (full_mode)
        1:       bus.NPU_FULL = (c >= 7 && c <= 9);
        2:       bus.NPU_FULL = ($urandom_range(0, 3) == 0);
        default: bus.NPU_FULL = 1'b0;
      endcase
      bus.OUT_READY = (sink_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLKEXT);
      if (abort_cyc > 0 && c == abort_cyc + 1) begin
        chk("abort_busy",  32'(bus.BUSY), 32'd0);
        chk("abort_en",    32'({bus.EN_CONFIG, bus.EN_FSM, bus.RD_EN, bus.OUT_VALID}), 32'd0);
        chk("abort_dadd",  {bus.DA, bus.DB, bus.DC, bus.DD}, 32'd0);
        chk("abort_ready", 32'(bus.IN_READY), 32'd0);
        ended = 1'b1;
      end else begin
        if (c == 1) begin
          chk("cfg_en",   32'(bus.EN_CONFIG), 32'd1);
          chk("cfg_dadb", 32'({bus.DA, bus.DB}), 32'(cfg));
          chk("cfg_err",  32'(bus.ERR), 32'd0);
        end
        if (c == 2) begin
          chk("gap_en",   32'({bus.EN_CONFIG, bus.EN_FSM}), 32'd0);
          chk("gap_dadb", 32'({bus.DA, bus.DB}), 32'(cfg));
        end
        if (c == 3) begin
          chk("ena_fsm",  32'({bus.EN_CONFIG, bus.EN_FSM}), 32'd1);
          chk("ena_dadd", {bus.DA, bus.DB, bus.DC, bus.DD}, 32'd0);
        end
        if (c == 4) chk("ena_drop", 32'(bus.EN_FSM), 32'd0);
        chk("in_ready", 32'(bus.IN_READY), 32'(c >= 4 && sent < nv && !bus.NPU_FULL));
        if (nv > 0 && c >= 4 && (sent < nv || c == t_last + 1))
          chk("quad_out", {bus.DA, bus.DB, bus.DC, bus.DD}, last_quad);
        if (bus.IN_VALID && bus.IN_READY) begin
          last_quad = bus.IN_DATA;
          sent++;
          if (sent == nv) begin
            t_last = c;
            ws     = c + 1;
          end
        end
        if (ws > 0 && c >= ws && c < ws + LAT) chk("wait_rd", 32'(bus.RD_EN), 32'd0);
        if (bus.RD_EN) begin
          if (first_rd < 0) first_rd = c;
          rd_cnt++;
          pop_pend = 1'b1;
          chk("rd_single", 32'(bus.OUT_VALID), 32'd0);
        end
        if (bus.OUT_VALID && bus.OUT_READY) begin
          acc++;
          if (exp_q.size() == 0) chk("out_extra", 32'(acc), 32'(nout));
          else chk("out_data", 32'(bus.OUT_DATA), 32'(exp_q.pop_front()));
        end
        if (bus.DONE) begin
          done_cnt++;
          chk("done_acc", 32'(acc), 32'(nout));
          if (nout == 0) chk("done_time", 32'(c), 32'(ws + LAT));
        end
        if (bus.BUSY) busy_cyc++;
        else ended = 1'b1;
      end
    end
    chk("run_ended", 32'(ended), 32'd1);
    if (abort_cyc == 0 && !stuck) begin
      chk("done_once", 32'(done_cnt), 32'd1);
      chk("rd_count",  32'(rd_cnt), 32'(nout));
      chk("xfer_cnt",  32'(sent), 32'(nv));
      chk("err_clear", 32'(bus.ERR), 32'd0);
      if (nout > 0) chk("first_rd", 32'(first_rd), 32'(ws + LAT + 1));
      else          chk("busy_len", 32'(busy_cyc), 32'(ws + LAT));
    end
    if (stuck) begin
      chk("tmo_err",  32'(bus.ERR), 32'd1);
      chk("tmo_done", 32'(done_cnt), 32'd0);
      chk("tmo_len",  32'(busy_cyc), 32'(ws - 1 + LAT + TMO));
    end
    @(posedge CLKEXT); #1;
    empty_stuck = 1'b0;
    idle_inputs();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.SSFR_CFG = 16'h0;
    bus.NUM_VEC  = '0;
    bus.NUM_OUT  = '0;
    idle_inputs();
    repeat (3) @(posedge CLKEXT);
    #1 RST_GLO = 1'b0;
    @(negedge CLKEXT);
    chk("rst_flags", 32'({bus.BUSY, bus.DONE, bus.ERR}), 32'd0);
    chk("rst_ctrl",  32'({bus.EN_CONFIG, bus.EN_FSM, bus.RD_EN, bus.OUT_VALID, bus.IN_READY}), 32'd0);
    chk("rst_dadd",  {bus.DA, bus.DB, bus.DC, bus.DD}, 32'd0);
    chk("rst_out",   32'(bus.OUT_DATA), 32'd0);

    run(16'h2280, 9, 4, 0, 1, 1'b0, 0);                     // basic run, toggling sink
    run(16'($urandom()), 9, 4, 1, 0, 1'b0, 0);              // FULL for 3 cycles mid-stream
    run(16'($urandom()), $urandom_range(1, 20), $urandom_range(1, 10), 2, 1, 1'b0, 0);
    run(16'($urandom()), 0, 0, 0, 0, 1'b0, 0);              // empty run: ENA->WAIT->FIN
    run(16'($urandom()), 1, 1, 0, 0, 1'b0, 0);              // single quad / single byte
    run(16'($urandom()), 9, 3, 0, 0, 1'b0, 8);              // ABORT during STREAM
    run(16'($urandom()), 9, 3, 2, 1, 1'b0, 0);              // clean run after abort

    // START together with ABORT in IDLE: ABORT wins
    @(posedge CLKEXT); #1;
    bus.START = 1'b1;
    bus.ABORT = 1'b1;
    @(posedge CLKEXT); #1;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    @(negedge CLKEXT);
    chk("start_abort", 32'({bus.BUSY, bus.EN_CONFIG}), 32'd0);

    run(16'($urandom()), 0, 2, 0, 0, 1'b1, 0);              // EMPTY stuck -> drain timeout
    repeat (3) @(negedge CLKEXT);
    chk("err_sticky", 32'(bus.ERR), 32'd1);
    run(16'($urandom()), 4, 2, 0, 1, 1'b0, 0);              // next START clears ERR

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
